// File: rtl/fetch_unit.sv
// fetch_unit: program counter and req/ack instruction fetch with branch redirect and stall.
// Optional mem_ack watchdog with a sticky fetch_err when FETCH_TIMEOUT_EN is defined.
module fetch_unit #(
  parameter int ADDR_BIT = 16,
  parameter int INSTR_BIT = 16,
  parameter logic [ADDR_BIT-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 stall,
  input  logic                 branch_valid,
  input  logic [ADDR_BIT-1:0]  branch_target,
  output logic                 mem_req,
  output logic [ADDR_BIT-1:0]  mem_addr,
  input  logic                 mem_ack,
  input  logic [INSTR_BIT-1:0] mem_rdata,
  output logic [INSTR_BIT-1:0] instr,
  output logic                 instr_valid,
  output logic [ADDR_BIT-1:0]  instr_pc,
  output logic                 fetch_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2;
  logic [1:0] state, state_nxt;
  logic [ADDR_BIT-1:0] pc, pc_nxt;
  logic take, keep, timeout;
  if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
    $error("TIMEOUT must fit the 4-bit wait counter (1..15)");
  end
  assign take = state == REQ && mem_ack;
  assign keep = take && !branch_valid;
  assign pc_nxt = branch_valid ? branch_target : take ? pc + ADDR_BIT'(1) : pc;
  // a REQ still waiting for its ack ignores stall; otherwise stall parks the unit in HOLD
  assign state_nxt = (!enable || fetch_err || timeout) ? IDLE :
                     state == IDLE ? REQ :
                     (state == REQ && !mem_ack) ? REQ :
                     stall ? HOLD : REQ;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      mem_req <= 1'b0;
      mem_addr <= RESET_PC;
      instr <= '0;
      instr_valid <= 1'b0;
      instr_pc <= '0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      mem_req <= state_nxt == REQ;
      mem_addr <= pc_nxt;
      instr_valid <= keep;
      if (keep) begin
        instr <= mem_rdata;
        instr_pc <= pc;
      end
    end
`ifdef FETCH_TIMEOUT_EN
  logic [3:0] wait_cnt;
  assign timeout = state == REQ && !mem_ack && wait_cnt == 4'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_cnt <= '0;
      fetch_err <= 1'b0;
    end else begin
      wait_cnt <= (state == REQ && !mem_ack) ? wait_cnt + 4'd1 : '0;
      if (timeout) fetch_err <= 1'b1;
    end
`else
  assign timeout = 1'b0;
  assign fetch_err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and hand-sequenced checks of fetch_unit with an instruction scoreboard.
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic enable = 1'b0, stall = 1'b0, branch_valid = 1'b0, mem_ack = 1'b0;
  logic [15:0] branch_target = '0, mem_rdata = '0;
  logic mem_req, instr_valid, fetch_err;
  logic [15:0] mem_addr, instr, instr_pc;
  logic en_w = 1'b0, ack_w = 1'b0, req_w, iv_w, err_w;
  logic [15:0] rdata_w = '0, addr_w, instr_w, ipc_w;
  logic zero1 = 1'b0;
  logic [15:0] zero16 = '0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .fetch_err(fetch_err)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst(rst), .enable(en_w), .stall(zero1), .branch_valid(zero1),
    .branch_target(zero16), .mem_req(req_w), .mem_addr(addr_w), .mem_ack(ack_w),
    .mem_rdata(rdata_w), .instr(instr_w), .instr_valid(iv_w), .instr_pc(ipc_w),
    .fetch_err(err_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, stall, br;
    logic [15:0] tgt;
    logic ack;
    logic [15:0] rdata;
    logic req;
    logic [15:0] addr;
  } vec_t;
  typedef struct { logic [15:0] pc, data; } exp_t;

  vec_t tbl[$];
  exp_t q[$];
  int nvec = 0, nerr = 0, nvalid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic en, input logic st, input logic br, input logic [15:0] tgt,
                     input logic ack, input logic [15:0] rd, input logic req, input logic [15:0] addr);
    tbl.push_back('{en, st, br, tgt, ack, rd, req, addr});
  endtask

  // each accepted ack must produce exactly one instr_valid on the following cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (instr_valid || q.size() != 0) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL spurious_valid: instr_valid=1 instr_pc=%h, no accepted ack", instr_pc);
      end else begin
        e = q.pop_front();
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        if (instr_valid) begin
          nvalid++;
          chk("instr", {16'd0, instr}, {16'd0, e.data});
          chk("instr_pc", {16'd0, instr_pc}, {16'd0, e.pc});
        end
      end
    end
  end

  initial begin
    int n0;
    logic prev_req, prev_ack;
    logic [15:0] apc;
    row(1,0,0,16'h0000,0,16'h0000, 0,16'h0000);
    row(1,0,0,16'h0000,1,16'h0100, 1,16'h0000);
    row(1,0,0,16'h0000,0,16'h0000, 1,16'h0001);
    row(1,0,0,16'h0000,1,16'h0101, 1,16'h0001);
    row(1,0,0,16'h0000,1,16'h0102, 1,16'h0002);
    row(1,0,1,16'h0040,1,16'hDEAD, 1,16'h0003);
    row(1,0,0,16'h0000,0,16'h0000, 1,16'h0040);
    row(1,1,0,16'h0000,1,16'hBEEF, 1,16'h0040);
    row(1,1,0,16'h0000,1,16'h1111, 0,16'h0041);
    row(1,0,0,16'h0000,0,16'h0000, 0,16'h0041);
    row(0,0,0,16'h0000,1,16'h2222, 1,16'h0041);
    row(0,0,1,16'h0080,0,16'h0000, 0,16'h0042);
    row(1,0,0,16'h0000,0,16'h0000, 0,16'h0080);
    row(1,0,1,16'h0090,0,16'h0000, 1,16'h0080);
    row(1,1,1,16'h00A0,1,16'h3333, 1,16'h0090);
    row(1,0,0,16'h0000,0,16'h0000, 0,16'h00A0);
    row(0,0,0,16'h0000,0,16'h0000, 1,16'h00A0);
    row(0,0,0,16'h0000,0,16'h0000, 0,16'h00A0);

    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_ipc", {16'd0, instr_pc}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_wrap_addr", {16'd0, addr_w}, 32'h0000FFFF);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      chk($sformatf("row%0d_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
      chk($sformatf("row%0d_addr", i), {16'd0, mem_addr}, {16'd0, tbl[i].addr});
      enable = tbl[i].en;
      stall = tbl[i].stall;
      branch_valid = tbl[i].br;
      branch_target = tbl[i].tgt;
      mem_ack = tbl[i].ack;
      mem_rdata = tbl[i].rdata;
      if (tbl[i].ack && tbl[i].req && !tbl[i].br) q.push_back('{tbl[i].addr, tbl[i].rdata});
    end
    @(negedge clk);
    chk("instr_hold", {16'd0, instr}, 32'h2222);
    chk("instr_pc_hold", {16'd0, instr_pc}, 32'h0041);

    enable = 1'b1;
    @(negedge clk);
    chk("wait_req", {31'd0, mem_req}, 32'd1);
    chk("wait_addr", {16'd0, mem_addr}, 32'h00A0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_addr", {16'd0, mem_addr}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("restart_req", {31'd0, mem_req}, 32'd1);
    chk("restart_addr", {16'd0, mem_addr}, 32'd0);

    n0 = nvalid;
    apc = '0;
    prev_req = mem_req;
    prev_ack = 1'b0;
    repeat (6) begin
      @(negedge clk);
      mem_ack = mem_req && prev_req && !prev_ack;
      mem_rdata = mem_addr + 16'h0100;
      if (mem_ack) begin
        q.push_back('{apc, apc + 16'h0100});
        apc++;
      end
      prev_req = mem_req;
      prev_ack = mem_ack;
    end
    @(negedge clk);
    mem_ack = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("auto_words", nvalid - n0, 32'd3);
    chk("auto_idle_req", {31'd0, mem_req}, 32'd0);

    en_w = 1'b1;
    @(negedge clk);
    chk("wrap_req", {31'd0, req_w}, 32'd1);
    chk("wrap_addr", {16'd0, addr_w}, 32'h0000FFFF);
    ack_w = 1'b1;
    rdata_w = 16'h1234;
    @(negedge clk);
    ack_w = 1'b0;
    en_w = 1'b0;
    chk("wrap_valid", {31'd0, iv_w}, 32'd1);
    chk("wrap_instr", {16'd0, instr_w}, 32'h1234);
    chk("wrap_ipc", {16'd0, ipc_w}, 32'h0000FFFF);
    chk("wrap_next_addr", {16'd0, addr_w}, 32'd0);

    enable = 1'b1;
    repeat (16) @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
    chk("timeout_err", {31'd0, fetch_err}, 32'd1);
    chk("timeout_req", {31'd0, mem_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("timeout_stays_idle", {31'd0, mem_req}, 32'd0);
`else
    chk("noto_err", {31'd0, fetch_err}, 32'd0);
    chk("noto_req", {31'd0, mem_req}, 32'd1);
    repeat (3) @(negedge clk);
    chk("noto_still_req", {31'd0, mem_req}, 32'd1);
`endif
    enable = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
